raw2rgb: RTL and testbench
==========================

RAW2RGB -- requirements
Module: raw2rgb

Interface
REQ-001 SHALL have parameter WIDTH, default 1920, active pixels per line.
REQ-002 SHALL have parameter HEIGHT, default 1080, active lines per frame.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port sink_data  input  8  Bayer raw sample or packet-header beat.
REQ-006 SHALL have sink_valid, sink_sop, sink_eop (input, 1 each): Avalon-ST beat qualifiers; sink_ready (output, 1): beat accepted when sink_valid & sink_ready.
REQ-007 SHALL have port source_data  output  24  RGB pixel {C2[23:16], C1[15:8], C0[7:0]}.
REQ-008 SHALL have source_valid, source_sop, source_eop (output, 1 each) and source_ready (input, 1).

Function
REQ-009 SHALL run a packet FSM: IDLE, VIDEO, CTRL.
REQ-010 IDLE: accepted sop beat with data 8'h0 -> VIDEO; sop beat with nonzero data -> CTRL.
REQ-011 VIDEO/CTRL: accepted eop beat -> IDLE; accepted sop beat restarts the FSM per REQ-010 and clears x_cnt/y_cnt.
REQ-012 Header beat SHALL be forwarded as {16'h0, sink_data}; CTRL payload beats likewise zero-extended, unprocessed.
REQ-013 x_cnt/y_cnt (16 bit) SHALL advance per accepted VIDEO payload beat; x wraps WIDTH-1 -> 0 and increments y; y saturates at HEIGHT-1.
REQ-014 Bayer map: (x even, y even)=C0; (x odd, y odd)=C2; mixed parity=C1.
REQ-015 Each VIDEO pixel SHALL use 2x2 window (x-1,y-1),(x,y-1),(x-1,y),(x,y); window holds one C0, one C2, two C1.
REQ-016 C0/C2 outputs = window sample of that colour; C1 = (sum of two C1 samples) >> 1, 9-bit sum, truncate.
REQ-017 Samples outside the frame (x=0 column-left, y=0 row-above) SHALL read as 0.
REQ-018 Row-above samples SHALL come from a WIDTH x 8 line buffer, read-before-write at address x_cnt.
REQ-019 Latency exactly 1 cycle: accepted beat at edge N appears on source_* after edge N, sop/eop aligned with data.
REQ-020 sink_ready = source_ready | ~source_valid (combinational); output registers load only on accept.
REQ-021 source_valid SHALL clear when source_ready=1 and no beat accepted; outputs hold while source_ready=0.
REQ-022 eop earlier than WIDTH*HEIGHT pixels SHALL end frame normally; surplus pixels are demosaiced with saturated y, no error.

Reset
REQ-023 rst SHALL force FSM IDLE, x_cnt=y_cnt=0, source_valid/sop/eop=0, source_data=24'h0, left-neighbour regs=0.
REQ-024 Line-buffer contents SHALL NOT be reset; y=0 masking per REQ-017 makes them don't-care.
REQ-025 rst mid-frame SHALL drop the frame; next output only after a new sop.

Configuration
REQ-026 With RAW2RGB_GREEN_AVG_EN defined, C1 SHALL follow REQ-016.
REQ-027 Without RAW2RGB_GREEN_AVG_EN, C1 SHALL be the current-row C1 sample only (no adder); C0/C2 unchanged.

Structure
REQ-028 Package raw2rgb_pkg SHALL hold FSM state enum, VIDEO_TYPE constant (4'h0), Bayer colour enum and channel bit-range constants.
REQ-029 Line buffer SHALL be sub-module raw2rgb_linebuf (parameterised depth/width, sync read, read-before-write).

Verification (WIDTH=4, HEIGHT=2, GREEN_AVG on unless stated)
REQ-030 Frame header 0, rows 10,20,30,40 / 50,60,70,80, source_ready=1 -> 9 output beats; first 24'h000000 with sop; pixel(0,0)=24'h00000A.
REQ-031 Same frame -> pixel(1,1)=24'h3C230A, pixel(2,1)=24'h3C2D1E, last beat has eop.
REQ-032 Same frame, macro undefined -> pixel(1,1)=24'h3C320A, pixel(2,1)=24'h3C461E.
REQ-033 source_ready toggled 1/0 every cycle -> identical output sequence, no beat lost or duplicated, sink_ready low only while source_valid & ~source_ready.
REQ-034 Control packet header 8'h0F, payload 8'hAB, eop -> beats 24'h00000F, 24'h0000AB; counters stay 0.
REQ-035 rst asserted after 3 pixels, then full frame -> outputs 0 during reset; subsequent frame matches REQ-030/031.

Source files
------------

// File: rtl/raw2rgb_pkg.sv
// raw2rgb_pkg -- shared types and constants for the raw2rgb Bayer demosaic block.
//   pkt_state_e : packet FSM states (idle / video packet / control packet)
//   VIDEO_TYPE  : packet-type nibble that marks a video packet header
//   bayer_col_e : colour of a Bayer site; bayer_col() maps (x,y) parity to it
//   C*_LSB/CH_W : bit ranges of the three channels inside the 24-bit pixel
package raw2rgb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_VIDEO = 2'd1,
        ST_CTRL  = 2'd2
    } pkt_state_e;

    localparam logic [3:0] VIDEO_TYPE = 4'h0;

    typedef enum logic [1:0] {
        COL_C0 = 2'd0,
        COL_C1 = 2'd1,
        COL_C2 = 2'd2
    } bayer_col_e;

    localparam int CH_W   = 8;
    localparam int C0_LSB = 0;
    localparam int C1_LSB = 8;
    localparam int C2_LSB = 16;

    function automatic bayer_col_e bayer_col(input logic x_odd, input logic y_odd);
        if (!x_odd && !y_odd) return COL_C0;
        else if (x_odd && y_odd) return COL_C2;
        else return COL_C1;
    endfunction

endpackage

// File: rtl/raw2rgb_linebuf.sv
// raw2rgb_linebuf -- single-line sample store for the row above.
//   clk     : clock
//   wr_en   : write wr_data at wr_addr
//   rd_addr : registered read address; rd_data valid the cycle after
//   rd_data : mem[rd_addr] as it was before any write on the same edge
// Contents are never reset: the consumer masks the first row of every frame.
module raw2rgb_linebuf
    import raw2rgb_pkg::*;
#(
    parameter int DEPTH = 1920,
    parameter int DW    = 8,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/raw2rgb.sv
// raw2rgb -- Avalon-ST Bayer raw to 24-bit RGB demosaic, one-cycle latency.
//   clk, rst            : clock, asynchronous active-high reset
//   sink_*              : raw input stream (header beat + 8-bit samples)
//   source_*            : pixel output stream {C2, C1, C0}
// Each video pixel is built from the 2x2 window ending at (x,y). Control
// packets and headers pass through zero-extended.
// Build option: RAW2RGB_GREEN_AVG_EN averages both C1 samples of the window;
// without it C1 is the current-row C1 sample.
module raw2rgb
    import raw2rgb_pkg::*;
#(
    parameter int WIDTH  = 1920,
    parameter int HEIGHT = 1080
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  sink_data,
    input  logic        sink_valid,
    input  logic        sink_sop,
    input  logic        sink_eop,
    output logic        sink_ready,
    output logic [23:0] source_data,
    output logic        source_valid,
    output logic        source_sop,
    output logic        source_eop,
    input  logic        source_ready
);

    localparam int AW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    pkt_state_e  state, state_nxt;
    logic [15:0] x_cnt, y_cnt, x_nxt, y_nxt;
    logic [7:0]  left_cur, left_up, lb_q;
    logic [7:0]  s_left, s_up, s_ul;
    logic [7:0]  c0, c1, c2, g_a;
    logic [23:0] rgb, out_data;
    logic        accept, hdr_beat, pix_beat, ctl_beat, out_load;

    assign sink_ready = source_ready | ~source_valid;
    assign accept     = sink_valid & sink_ready;
    assign hdr_beat   = accept & sink_sop;
    assign pix_beat   = accept & ~sink_sop & (state == ST_VIDEO);
    assign ctl_beat   = accept & ~sink_sop & (state == ST_CTRL);

    // ---------------- packet FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (hdr_beat)
            state_nxt = (sink_data == {4'h0, VIDEO_TYPE}) ? ST_VIDEO : ST_CTRL;
        else if (accept && sink_eop && state != ST_IDLE)
            state_nxt = ST_IDLE;
    end

    // Payload beats outside a packet are swallowed without output.
    always_comb begin
        out_load = hdr_beat | pix_beat | ctl_beat;
        out_data = pix_beat ? rgb : {16'h0, sink_data};
    end

    // ---------------- position counters ----------------
    always_comb begin
        x_nxt = x_cnt;
        y_nxt = y_cnt;
        if (hdr_beat) begin
            x_nxt = '0;
            y_nxt = '0;
        end else if (pix_beat) begin
            if (x_cnt == 16'(WIDTH - 1)) begin
                x_nxt = '0;
                if (y_cnt != 16'(HEIGHT - 1)) y_nxt = y_cnt + 16'd1;
            end else begin
                x_nxt = x_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_cnt    <= '0;
            y_cnt    <= '0;
            left_cur <= '0;
            left_up  <= '0;
        end else begin
            x_cnt <= x_nxt;
            y_cnt <= y_nxt;
            if (pix_beat) begin
                left_cur <= sink_data;
                left_up  <= lb_q;
            end
        end
    end

    // The read is issued with the upcoming x so that lb_q already holds the
    // row-above sample for x_cnt when that pixel arrives. The write goes to
    // the current x; both addresses only coincide when nothing is written.
    raw2rgb_linebuf #(.DEPTH(WIDTH), .DW(8), .AW(AW)) u_linebuf (
        .clk     (clk),
        .wr_en   (pix_beat),
        .wr_addr (x_cnt[AW-1:0]),
        .wr_data (sink_data),
        .rd_addr (x_nxt[AW-1:0]),
        .rd_data (lb_q)
    );

    // ---------------- 2x2 window and demosaic ----------------
    always_comb begin
        s_left = (x_cnt == '0) ? 8'h0 : left_cur;
        s_up   = (y_cnt == '0) ? 8'h0 : lb_q;
        s_ul   = (x_cnt == '0 || y_cnt == '0) ? 8'h0 : left_up;
    end

    // g_a is always the C1 sample on the current row.
    always_comb begin
        c0  = 8'h0;
        c2  = 8'h0;
        g_a = 8'h0;
        case (bayer_col(x_cnt[0], y_cnt[0]))
            COL_C0: begin c0 = sink_data; c2 = s_ul;      g_a = s_left; end
            COL_C2: begin c0 = s_ul;      c2 = sink_data; g_a = s_left; end
            default: begin
                g_a = sink_data;
                if (x_cnt[0]) begin c0 = s_left; c2 = s_up;   end
                else          begin c0 = s_up;   c2 = s_left; end
            end
        endcase
    end

`ifdef RAW2RGB_GREEN_AVG_EN
    logic [7:0] g_b;
    logic [8:0] g_sum;
    // Second C1 is diagonal on C1 sites, directly above on C0/C2 sites.
    always_comb begin
        g_b   = (x_cnt[0] ^ y_cnt[0]) ? s_ul : s_up;
        g_sum = {1'b0, g_a} + {1'b0, g_b};
        c1    = g_sum[8:1];
    end
`else
    assign c1 = g_a;
`endif

    always_comb begin
        rgb = 24'h0;
        rgb[C0_LSB +: CH_W] = c0;
        rgb[C1_LSB +: CH_W] = c1;
        rgb[C2_LSB +: CH_W] = c2;
    end

    // ---------------- output register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            source_valid <= 1'b0;
            source_sop   <= 1'b0;
            source_eop   <= 1'b0;
            source_data  <= 24'h0;
        end else if (out_load) begin
            source_valid <= 1'b1;
            source_sop   <= sink_sop;
            source_eop   <= sink_eop;
            source_data  <= out_data;
        end else if (sink_ready) begin
            source_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_raw2rgb.sv
module tb_raw2rgb;

    localparam int W = 4;
    localparam int H = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  sink_data;
    logic        sink_valid, sink_sop, sink_eop, sink_ready;
    logic [23:0] source_data;
    logic        source_valid, source_sop, source_eop, source_ready;

    int tests = 0;
    int fails = 0;
    int rdy_mode = 0;      // 0: always ready, 1: toggle, 2: random
    bit chk_ready = 1'b0;

    logic [25:0] got[$];   // {sop, eop, data}
    logic [25:0] exp[$];
    logic [7:0]  strm[$];  // payload of the packet being sent

    raw2rgb #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk(clk), .rst(rst),
        .sink_data(sink_data), .sink_valid(sink_valid), .sink_sop(sink_sop),
        .sink_eop(sink_eop), .sink_ready(sink_ready),
        .source_data(source_data), .source_valid(source_valid),
        .source_sop(source_sop), .source_eop(source_eop), .source_ready(source_ready)
    );

    always #5 clk = ~clk;

    initial begin
        source_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: source_ready = 1'b1;
                1: source_ready = ~source_ready;
                default: source_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Beats are captured at the falling edge; they transfer on the next rise.
    always @(negedge clk) begin
        if (!rst) begin
            if (chk_ready) begin
                tests++;
                if (sink_ready !== (source_ready | ~source_valid)) begin
                    fails++;
                    $display("FAIL sink_ready: got %b want %b", sink_ready, source_ready | ~source_valid);
                end
            end
            if (source_valid && source_ready)
                got.push_back({source_sop, source_eop, source_data});
        end
    end

    // Reference pixel: gather the 2x2 window by stream position, classify
    // each sample by its own coordinate parity.
    function automatic logic [23:0] ref_pix(input int n);
        int x, y, l, c0, c2, gsum, gcur;
        int sx[4], sy[4], sv[4];
        x = n % W;
        l = n / W;
        y = (l > H - 1) ? H - 1 : l;
        sx[0] = x;     sy[0] = y;     sv[0] = strm[n];
        sx[1] = x - 1; sy[1] = y;     sv[1] = (x > 0) ? strm[n-1] : 0;
        sx[2] = x;     sy[2] = y - 1; sv[2] = (y > 0) ? strm[n-W] : 0;
        sx[3] = x - 1; sy[3] = y - 1; sv[3] = (x > 0 && y > 0) ? strm[n-W-1] : 0;
        c0 = 0; c2 = 0; gsum = 0; gcur = 0;
        for (int k = 0; k < 4; k++) begin
            if ((sx[k] & 1) == 0 && (sy[k] & 1) == 0) c0 = sv[k];
            else if ((sx[k] & 1) == 1 && (sy[k] & 1) == 1) c2 = sv[k];
            else begin
                gsum += sv[k];
                if (sy[k] == y) gcur = sv[k];
            end
        end
`ifdef RAW2RGB_GREEN_AVG_EN
        return {8'(c2), 8'(gsum / 2), 8'(c0)};
`else
        return {8'(c2), 8'(gcur), 8'(c0)};
`endif
    endfunction

    task automatic idle(input int n);
        sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic s, input logic e);
        int n = 0;
        bit rdy;
        sink_data = d; sink_sop = s; sink_eop = e; sink_valid = 1'b1;
        forever begin
            @(negedge clk);
            rdy = sink_ready;
            @(posedge clk);
            if (rdy) break;
            n++;
            if (n > 50) begin
                tests++; fails++;
                $display("FAIL send_timeout: got no sink_ready in %0d cycles, want acceptance", n);
                break;
            end
        end
        #1;
        sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
    endtask

    // Send header + strm payload, append the expected output beats.
    task automatic run_packet(input logic [7:0] hdr, input int gap_max);
        exp.push_back({1'b1, 1'b0, 16'h0, hdr});
        send(hdr, 1'b1, 1'b0);
        idle($urandom_range(0, gap_max));
        for (int n = 0; n < strm.size(); n++) begin
            logic last;
            last = (n == strm.size() - 1);
            if (hdr == 8'h0) exp.push_back({1'b0, last, ref_pix(n)});
            else             exp.push_back({1'b0, last, 16'h0, strm[n]});
            send(strm[n], 1'b0, last);
            idle($urandom_range(0, gap_max));
        end
    endtask

    task automatic compare_stream(input string name);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (got.size() >= exp.size() && !source_valid) break;
        end
        #1;
        tests++;
        if (got.size() != exp.size()) begin
            fails++;
            $display("FAIL %s_count: got %0d beats want %0d", name, got.size(), exp.size());
        end
        for (int i = 0; i < got.size() && i < exp.size(); i++) begin
            tests++;
            if (got[i] !== exp[i]) begin
                fails++;
                $display("FAIL %s_beat%0d: got %h want %h", name, i, got[i], exp[i]);
            end
        end
    endtask

    task automatic fixed_frame(input string name);
        logic [23:0] p11, p21;
`ifdef RAW2RGB_GREEN_AVG_EN
        p11 = 24'h3C230A; p21 = 24'h3C2D1E;
`else
        p11 = 24'h3C320A; p21 = 24'h3C461E;
`endif
        got.delete(); exp.delete();
        strm = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
        run_packet(8'h00, 0);
        compare_stream(name);
        tests += 5;
        if (got.size() != 9) begin
            fails += 5;
            $display("FAIL %s_const: got %0d beats want 9", name, got.size());
        end else begin
            if (got[0] !== {2'b10, 24'h000000}) begin fails++; $display("FAIL %s_hdr: got %h want %h", name, got[0], {2'b10, 24'h0}); end
            if (got[1] !== {2'b00, 24'h00000A}) begin fails++; $display("FAIL %s_p00: got %h want %h", name, got[1], {2'b00, 24'h00000A}); end
            if (got[6] !== {2'b00, p11}) begin fails++; $display("FAIL %s_p11: got %h want %h", name, got[6], {2'b00, p11}); end
            if (got[7] !== {2'b00, p21}) begin fails++; $display("FAIL %s_p21: got %h want %h", name, got[7], {2'b00, p21}); end
            if (got[8][24] !== 1'b1) begin fails++; $display("FAIL %s_eop: got %b want 1", name, got[8][24]); end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        sink_data = 8'h0; sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests += 2;
        if ({source_valid, source_sop, source_eop} !== 3'b000) begin
            fails++; $display("FAIL reset_flags: got %b want 000", {source_valid, source_sop, source_eop});
        end
        if (source_data !== 24'h0) begin
            fails++; $display("FAIL reset_data: got %h want 000000", source_data);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_frame;
        rdy_mode = 0;
        fixed_frame("frame");
    endtask

    task automatic test_ctrl;
        got.delete(); exp.delete();
        strm = '{8'hAB};
        run_packet(8'h0F, 0);
        compare_stream("ctrl");
        tests += 3;
        if (got.size() != 2 || got[0] !== {2'b10, 24'h00000F} || got[1] !== {2'b01, 24'h0000AB}) begin
            fails++; $display("FAIL ctrl_beats: got %0d beats first %h want 200000f,10000ab", got.size(), got.size() > 0 ? got[0] : 26'h0);
        end
        if (dut.x_cnt !== 16'h0) begin fails++; $display("FAIL ctrl_xcnt: got %0d want 0", dut.x_cnt); end
        if (dut.y_cnt !== 16'h0) begin fails++; $display("FAIL ctrl_ycnt: got %0d want 0", dut.y_cnt); end
    endtask

    task automatic test_backpressure;
        rdy_mode = 1;
        chk_ready = 1'b1;
        fixed_frame("toggle");
        got.delete(); exp.delete();
        strm.delete();
        for (int i = 0; i < W * H; i++) strm.push_back(8'($urandom));
        run_packet(8'h00, 1);
        compare_stream("toggle_rand");
        chk_ready = 1'b0;
        rdy_mode = 0;
    endtask

    task automatic test_random;
        rdy_mode = 2;
        chk_ready = 1'b1;
        for (int p = 0; p < 8; p++) begin
            logic [7:0] hdr;
            int len;
            got.delete(); exp.delete(); strm.delete();
            hdr = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            len = $urandom_range(1, W * H + 6);  // short frames and surplus pixels
            for (int i = 0; i < len; i++) strm.push_back(8'($urandom));
            run_packet(hdr, 2);
            compare_stream($sformatf("rand%0d", p));
        end
        chk_ready = 1'b0;
        rdy_mode = 0;
    endtask

    task automatic test_reset_mid;
        rdy_mode = 0;
        send(8'h00, 1'b1, 1'b0);
        send(8'd10, 1'b0, 1'b0);
        send(8'd20, 1'b0, 1'b0);
        send(8'd30, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        tests++;
        if ({source_valid, source_sop, source_eop, source_data} !== 27'h0) begin
            fails++; $display("FAIL midrst_out: got %b/%h want 0/000000", {source_valid, source_sop, source_eop}, source_data);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({source_valid, source_data} !== 25'h0) begin
            fails++; $display("FAIL midrst_hold: got %b/%h want 0/000000", source_valid, source_data);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        got.delete();
        send(8'h55, 1'b0, 1'b0);
        send(8'h66, 1'b0, 1'b1);
        idle(5);
        tests++;
        if (got.size() != 0) begin
            fails++; $display("FAIL midrst_stray: got %0d beats want 0", got.size());
        end
        fixed_frame("after_rst");
    endtask

    initial begin
        test_reset();
        test_frame();
        test_ctrl();
        test_frame();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
